// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/writeback
// sequencing with a sticky fault on illegal opcodes or data-memory timeout.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        dmem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        fault,
    output logic        timeout,
    output logic [31:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [2:0] C_BAD    = 3'd0;
    localparam logic [2:0] C_R      = 3'd1;
    localparam logic [2:0] C_I      = 3'd2;
    localparam logic [2:0] C_LOAD   = 3'd3;
    localparam logic [2:0] C_STORE  = 3'd4;
    localparam logic [2:0] C_BRANCH = 3'd5;

    localparam logic [8:0] WAIT_LIMIT = 9'(TIMEOUT);

    logic [2:0] state_r, state_nx;
    logic [2:0] cls_r;
    logic [7:0] wait_cnt;
    logic       timeout_r;
    logic       wait_expired;

    function automatic logic [2:0] classify(input logic [6:0] op);
        case (op)
            7'b0110011: classify = C_R;
            7'b0010011: classify = C_I;
            7'b0000011: classify = C_LOAD;
            7'b0100011: classify = C_STORE;
            7'b1100011: classify = C_BRANCH;
            default:    classify = C_BAD;
        endcase
    endfunction

    // This MEM cycle without dmem_ready would be the TIMEOUT-th one.
    assign wait_expired = ({1'b0, wait_cnt} + 9'd1) >= WAIT_LIMIT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_FETCH:  state_nx = run ? S_DECODE : S_FETCH;
            S_DECODE: state_nx = (classify(opcode) == C_BAD) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (cls_r)
                    C_R, C_I:         state_nx = S_WB;
                    C_LOAD, C_STORE:  state_nx = S_MEM;
                    C_BRANCH:         state_nx = S_FETCH;
                    default:          state_nx = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_nx = (cls_r == C_LOAD) ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    state_nx = S_FAULT;
                end
            end
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_FAULT;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 2'b00;
        // Gating on reset drops every strobe the instant reset rises.
        if (!reset) begin
            case (state_r)
                S_FETCH: ir_write = run;
                S_EXEC, S_MEM: begin
                    case (cls_r)
                        C_R:      begin alu_src = 1'b0; alu_op = 2'b10; end
                        C_I:      begin alu_src = 1'b1; alu_op = 2'b10; end
                        C_BRANCH: begin alu_src = 1'b0; alu_op = 2'b01; end
                        default:  begin alu_src = 1'b1; alu_op = 2'b00; end
                    endcase
                    if (state_r == S_EXEC && cls_r == C_BRANCH) begin
                        pc_write = 1'b1;
                        pc_src   = zero;
                    end
                    if (state_r == S_MEM) begin
                        mem_read  = (cls_r == C_LOAD);
                        mem_write = (cls_r == C_STORE);
                        pc_write  = (cls_r == C_STORE) && dmem_ready;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    mem_to_reg = (cls_r == C_LOAD);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_r     <= C_BAD;
            wait_cnt  <= 8'd0;
            timeout_r <= 1'b0;
            retired   <= 32'd0;
        end else begin
            if (state_r == S_DECODE) cls_r <= classify(opcode);
            if (state_r != S_MEM) begin
                wait_cnt <= 8'd0;
            end else if (!dmem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state_r == S_MEM && !dmem_ready && wait_expired) timeout_r <= 1'b1;
            if (pc_write) retired <= retired + 32'd1;
        end
    end

    assign state   = state_r;
    assign fault   = (state_r == S_FAULT);
    assign timeout = timeout_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT=4) with hand-computed expectations.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset, run, zero, dmem_ready;
    logic [6:0]  opcode;
    logic        ir_write, pc_write, pc_src, mem_read, mem_write, reg_write;
    logic        alu_src, mem_to_reg, fault, timeout;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .dmem_ready(dmem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .state(state), .fault(fault), .timeout(timeout),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; zero = 1'b0; dmem_ready = 1'b0; opcode = OP_R;
        step(); step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_irw", 32'(ir_write), 32'd0);
        chk("rst_strobes", {26'd0, pc_write, mem_read, mem_write, reg_write, fault, timeout}, 32'd0);
        chk("rst_aluop", 32'(alu_op), 32'd0);
        chk("rst_retired", retired, 32'd0);

        // Idle in FETCH with run low.
        reset = 1'b0; run = 1'b0;
        step();
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_irw", 32'(ir_write), 32'd0);

        // R-type; run dropped mid-instruction must not abort it.
        run = 1'b1; #1;
        chk("r_irw", 32'(ir_write), 32'd1);
        step(); run = 1'b0;
        chk("r_dec", 32'(state), 32'd1);
        chk("r_dec_irw", 32'(ir_write), 32'd0);
        step();
        chk("r_exec", 32'(state), 32'd2);
        chk("r_exec_alu", {29'd0, alu_src, alu_op}, {29'd0, 1'b0, 2'b10});
        step();
        chk("r_wb", 32'(state), 32'd4);
        chk("r_wb_str", {29'd0, reg_write, pc_write, mem_to_reg}, 32'b110);
        step();
        chk("r_back", 32'(state), 32'd0);
        chk("r_retired", retired, 32'd1);
        chk("r_hold_irw", 32'(ir_write), 32'd0);
        step();
        chk("r_hold_state", 32'(state), 32'd0);

        // I-type
        run = 1'b1; opcode = OP_I;
        step(); step();
        chk("i_exec_alu", {29'd0, alu_src, alu_op}, {29'd0, 1'b1, 2'b10});
        step();
        chk("i_wb", {29'd0, reg_write, pc_write, mem_to_reg}, 32'b110);
        step();
        chk("i_retired", retired, 32'd2);

        // Branch taken then not taken, 3 cycles each.
        opcode = OP_BR; zero = 1'b1;
        step(); step();
        chk("bt_exec", 32'(state), 32'd2);
        chk("bt_pc", {29'd0, pc_write, pc_src, reg_write}, 32'b110);
        chk("bt_aluop", 32'(alu_op), 32'd1);
        step();
        chk("bt_back", 32'(state), 32'd0);
        zero = 1'b0;
        step(); step();
        chk("bn_pc", {30'd0, pc_write, pc_src}, 32'b10);
        step();
        chk("bn_back", 32'(state), 32'd0);
        chk("br_retired", retired, 32'd4);

        // Load: 3 wait cycles, ready on 4th MEM cycle (also ready-beats-timeout).
        opcode = OP_LD;
        step(); step();
        chk("ld_exec_alu", {29'd0, alu_src, alu_op}, {29'd0, 1'b1, 2'b00});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ld_mem_wait", {29'd0, state}, 32'd3);
            chk("ld_mrd", {30'd0, mem_read, mem_write}, 32'b10);
        end
        step(); dmem_ready = 1'b1; #1;
        chk("ld_mem_last", {28'd0, state, mem_read}, {28'd0, 3'd3, 1'b1});
        chk("ld_nopc", 32'(pc_write), 32'd0);
        step(); dmem_ready = 1'b0;
        chk("ld_wb", 32'(state), 32'd4);
        chk("ld_wb_str", {29'd0, reg_write, pc_write, mem_to_reg}, 32'b111);
        chk("ld_wb_mrd", 32'(mem_read), 32'd0);
        step();
        chk("ld_back", 32'(state), 32'd0);
        chk("ld_retired", retired, 32'd5);

        // Store completing on the 4th MEM cycle.
        opcode = OP_ST;
        step(); step(); step(); step(); step();
        chk("st_mem3", {30'd0, mem_read, mem_write}, 32'b01);
        step(); dmem_ready = 1'b1; #1;
        chk("st_done", {29'd0, pc_write, pc_src, mem_write}, 32'b101);
        step(); dmem_ready = 1'b0;
        chk("st_back", 32'(state), 32'd0);
        chk("st_retired", retired, 32'd6);

        // Reset during 2nd MEM cycle of a store.
        step(); step(); step(); step();
        chk("rs_mem2", {28'd0, state, mem_write}, {28'd0, 3'd3, 1'b1});
        reset = 1'b1; #1;
        chk("rs_mw", {30'd0, mem_write, pc_write}, 32'd0);
        chk("rs_state", 32'(state), 32'd0);
        chk("rs_retired", retired, 32'd0);
        step();
        reset = 1'b0;

        // Store timeout: 4 MEM cycles without ready, then FAULT.
        step(); step(); step();
        for (int i = 0; i < 4; i++) begin
            chk("to_mem", {28'd0, state, mem_write}, {28'd0, 3'd3, 1'b1});
            step();
        end
        chk("to_state", 32'(state), 32'd7);
        chk("to_flags", {30'd0, fault, timeout}, 32'b11);
        chk("to_strobes", {27'd0, mem_write, mem_read, pc_write, reg_write, ir_write}, 32'd0);
        chk("to_retired", retired, 32'd0);
        dmem_ready = 1'b1;
        step(); step();
        chk("to_absorb", 32'(state), 32'd7);
        dmem_ready = 1'b0;

        // Reset clears, then illegal opcode faults from DECODE.
        reset = 1'b1; #1;
        chk("clr_flags", {27'd0, state, fault, timeout}, 32'd0);
        step(); reset = 1'b0; opcode = OP_XX;
        step();
        chk("ill_dec", 32'(state), 32'd1);
        chk("ill_dec_str", {28'd0, pc_write, reg_write, mem_write, mem_read}, 32'd0);
        step();
        chk("ill_state", 32'(state), 32'd7);
        chk("ill_flags", {30'd0, fault, timeout}, 32'b10);
        step();
        chk("ill_nostr", {27'd0, ir_write, pc_write, reg_write, mem_write, mem_read}, 32'd0);
        chk("ill_retired", retired, 32'd0);
        reset = 1'b1; #1;
        chk("ill_rst", {28'd0, state, fault}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum MEM-state cycles without dmem_ready before the block faults; legal range 1-255.
REQ-002 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: reset, asynchronous, active-high.
REQ-004 Port run, input, 1: when 1, allows a new instruction fetch.
REQ-005 Port opcode, input, 7: instruction[6:0] from the instruction register.
REQ-006 Port zero, input, 1: ALU zero flag.
REQ-007 Port dmem_ready, input, 1: data memory has accepted the write or returned the read this cycle.
REQ-008 Port ir_write, output, 1: load the instruction register.
REQ-009 Port pc_write, output, 1: update the PC.
REQ-010 Port pc_src, output, 1: PC source select; 0 = PC+4, 1 = branch target.
REQ-011 Port mem_read / mem_write, output, 1 each: data memory strobes.
REQ-012 Port reg_write, output, 1: register file write enable.
REQ-013 Port alu_src, output, 1: ALU B operand select; 1 = immediate.
REQ-014 Port mem_to_reg, output, 1: writeback source select; 1 = memory.
REQ-015 Port alu_op, output, 2: ALU control class; 00 add, 01 branch, 10 R/I.
REQ-016 Port state, output, 3: current FSM state.
REQ-017 Port fault, output, 1: sticky; set by an illegal opcode or a timeout.
REQ-018 Port timeout, output, 1: sticky; set only when the fault was caused by a timeout.
REQ-019 Port retired, output, 32: count of retired instructions.

Function
REQ-020 State encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7; codes 5 and 6 SHALL transition to FAULT.
REQ-021 FETCH with run=1 SHALL assert ir_write for exactly 1 cycle and then go to DECODE; FETCH with run=0 SHALL hold with all strobes 0.
REQ-022 DECODE SHALL classify the opcode:
- 0110011 = R
- 0010011 = I
- 0000011 = LOAD
- 0100011 = STORE
- 1100011 = BRANCH
- any other opcode SHALL go to FAULT with no write strobe asserted.
REQ-023 The opcode class SHALL be latched in DECODE and SHALL be the only class used in later states.
REQ-024 alu_src and alu_op SHALL be driven in EXEC and MEM as follows:
- R: 0 / 10
- I: 1 / 10
- LOAD and STORE: 1 / 00
- BRANCH: 0 / 01
REQ-025 In EXEC for BRANCH, pc_write SHALL be 1 and pc_src SHALL equal zero; the next state SHALL be FETCH.
REQ-026 In EXEC, R and I SHALL go to WB, and LOAD and STORE SHALL go to MEM.
REQ-027 In MEM, mem_read (LOAD) or mem_write (STORE) SHALL be held high until dmem_ready is sampled 1.
REQ-028 On dmem_ready in MEM, LOAD SHALL go to WB; STORE SHALL assert pc_write with pc_src=0 in that same cycle and go to FETCH.
REQ-029 Timeout counter in MEM:
- an 8-bit wait counter SHALL clear on MEM entry and increment each MEM cycle with dmem_ready=0;
- reaching TIMEOUT SHALL go to FAULT with timeout=1;
- dmem_ready=1 SHALL take priority over reaching TIMEOUT in the same cycle.
REQ-030 WB SHALL assert reg_write and pc_write (pc_src=0) for 1 cycle, with mem_to_reg=1 for LOAD and 0 otherwise, then go to FETCH.
REQ-031 Latency in cycles from FETCH entry to return to FETCH:
- BRANCH: 3
- R and I: 4
- STORE: 4+w
- LOAD: 5+w
where w = MEM wait cycles.
REQ-032 retired SHALL increment by 1 in each cycle where pc_write=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-033 run=0 SHALL NOT abort an instruction in progress; it SHALL take effect only in FETCH.
REQ-034 FAULT SHALL be absorbing (only reset exits it), with all strobes 0 and retired frozen.
REQ-035 All strobes outside the states named above SHALL be 0, and at most one of mem_read/mem_write SHALL be 1 in any cycle.

Reset
REQ-036 While reset=1, outputs SHALL be:
- state=FETCH
- all strobes, pc_src, alu_src, mem_to_reg, fault, timeout = 0
- alu_op=00
- retired=0
- wait counter=0
REQ-037 Reset asserted mid-instruction (including in MEM) SHALL immediately drop mem_read/mem_write/reg_write/pc_write without completing the access.
REQ-038 After reset deasserts, the first ir_write SHALL occur in the first cycle with run=1.

Verification
REQ-039 Scenario: run=1, opcode=0110011 -> states 0,1,2,4,0; reg_write high for 1 cycle in WB; retired=1.
REQ-040 Scenario: opcode=1100011 with zero=1, then repeated with zero=0 -> each takes 3 cycles; pc_write in EXEC with pc_src=1, then pc_src=0; retired=2.
REQ-041 Scenario: opcode=0000011, dmem_ready after 3 wait cycles -> mem_read high for 4 cycles; mem_to_reg=1 with reg_write in WB; total 8 cycles.
REQ-042 Scenario: opcode=0100011, TIMEOUT=4, dmem_ready held 0 -> FAULT after 4 MEM cycles; fault=1, timeout=1, mem_write=0 in FAULT; dmem_ready=1 on the 4th MEM cycle instead completes the store normally.
REQ-043 Scenario: opcode=1111111 -> FAULT from DECODE; fault=1, timeout=0; no strobes afterwards; reset returns state to 0 with fault=0.
REQ-044 Scenario: reset asserted during the 2nd MEM cycle of a store -> mem_write=0 immediately; no pc_write; retired unchanged at 0.
